// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// Channel count, select width, counter width and the idle output value.
package demux_pkg;
   localparam int unsigned CH_N  = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 16;
   // Value shown on a channel that holds no valid data
   localparam int unsigned IDLE_VAL = 0;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
// Ports: clk, rst, load/data (fill), ready (consumer take), valid/hold/free.
module demux_slot
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] hold,
   output logic             free
);

   // Free when empty or draining this cycle, so refill needs no bubble
   assign free = ~valid | ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         hold  <= WIDTH'(IDLE_VAL);
      end else if (load) begin
         valid <= 1'b1;
         hold  <= data;
      end else if (valid && ready) begin
         // Drained entries read as idle
         valid <= 1'b0;
         hold  <= WIDTH'(IDLE_VAL);
      end
   end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake.
// Ports: CLK, RST, EN, IN/SEL/IN_VALID/IN_READY, OUT0..3, OUT_VALID, OUT_READY, ACC_CNT.
module demux_stream
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [WIDTH-1:0]  IN,
   input  logic [SEL_W-1:0]  SEL,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic [WIDTH-1:0]  OUT0,
   output logic [WIDTH-1:0]  OUT1,
   output logic [WIDTH-1:0]  OUT2,
   output logic [WIDTH-1:0]  OUT3,
   output logic [CH_N-1:0]   OUT_VALID,
   input  logic [CH_N-1:0]   OUT_READY,
   output logic [CNT_W-1:0]  ACC_CNT
);

   logic [CH_N-1:0]  free;
   logic [CH_N-1:0]  load;
   logic [WIDTH-1:0] hold [CH_N];
   logic             accept;

   // Ready depends on SEL, never on IN_VALID
   assign IN_READY = EN & ~RST & free[SEL];
   assign accept   = IN_VALID & IN_READY;

   always_comb begin
      load = '0;
      if (accept) load[SEL] = 1'b1;
   end

   for (genvar n = 0; n < CH_N; n++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk   (CLK),
         .rst   (RST),
         .load  (load[n]),
         .data  (IN),
         .ready (OUT_READY[n]),
         .valid (OUT_VALID[n]),
         .hold  (hold[n]),
         .free  (free[n])
      );
   end

   assign OUT0 = hold[0];
   assign OUT1 = hold[1];
   assign OUT2 = hold[2];
   assign OUT3 = hold[3];

   always_ff @(posedge CLK) begin
      if (RST) ACC_CNT <= '0;
      else if (accept) ACC_CNT <= ACC_CNT + 1'b1;
   end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream against a per-channel array model.
// Directed scenarios plus randomized traffic and counter wrap.
module tb_demux_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  in_d;
   logic [1:0]  sel;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out0, out1, out2, out3;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] acc_cnt;

   int checks = 0;
   int errors = 0;

   // Reference: what each consumer should see, plus transfer count
   bit       mv [4];
   bit [7:0] md [4];
   bit [15:0] mcnt;

   always #5 clk = ~clk;

   demux_stream #(.WIDTH(8)) dut (
      .CLK(clk), .RST(rst), .EN(en), .IN(in_d), .SEL(sel),
      .IN_VALID(in_valid), .IN_READY(in_ready),
      .OUT0(out0), .OUT1(out1), .OUT2(out2), .OUT3(out3),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .ACC_CNT(acc_cnt)
   );

   function automatic logic [7:0] dout(int n);
      case (n)
         0: return out0;
         1: return out1;
         2: return out2;
         default: return out3;
      endcase
   endfunction

   // One clock of traffic; inputs already driven by caller
   task automatic step(input bit chk);
      bit exp_rdy;
      bit took;
      logic [3:0] ev;
      exp_rdy = en && !rst && (!mv[sel] || out_ready[sel]);
      took = exp_rdy && in_valid;
      #1;
      if (chk) begin
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready got=%b exp=%b", in_ready, exp_rdy);
         end
      end
      if (rst) begin
         for (int n = 0; n < 4; n++) begin mv[n] = 0; md[n] = 0; end
         mcnt = 0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (took && sel == n) begin
               mv[n] = 1; md[n] = in_d;
            end else if (mv[n] && out_ready[n]) begin
               mv[n] = 0; md[n] = 0;
            end
         end
         if (took) mcnt = mcnt + 16'd1;
      end
      @(posedge clk);
      #1;
      if (chk) begin
         for (int n = 0; n < 4; n++) ev[n] = mv[n];
         checks++;
         if (out_valid !== ev) begin
            errors++;
            $display("FAIL out_valid got=%b exp=%b", out_valid, ev);
         end
         for (int n = 0; n < 4; n++) begin
            checks++;
            if (dout(n) !== md[n]) begin
               errors++;
               $display("FAIL out%0d got=%h exp=%h", n, dout(n), md[n]);
            end
         end
         checks++;
         if (acc_cnt !== mcnt) begin
            errors++;
            $display("FAIL acc_cnt got=%0d exp=%0d", acc_cnt, mcnt);
         end
      end
   endtask

   task automatic idle_inputs();
      rst = 0; en = 1; in_valid = 0; in_d = 8'h00; sel = 2'd0;
      out_ready = 4'b0000;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step(1);
      rst = 0;
   endtask

   task automatic test_reset();
      en = 0; rst = 1; in_valid = 0; in_d = 0; sel = 0; out_ready = 0;
      step(1);
      checks++;
      if (out_valid !== 4'b0000 || acc_cnt !== 16'd0 || out2 !== 8'h00) begin
         errors++;
         $display("FAIL reset_state valid=%b cnt=%0d exp 0000/0", out_valid, acc_cnt);
      end
      rst = 0;
   endtask

   task automatic test_basic();
      do_reset();
      in_d = 8'hA5; sel = 2'd2; in_valid = 1;
      step(1);
      checks++;
      if (out2 !== 8'hA5 || out_valid !== 4'b0100 || acc_cnt !== 16'd1) begin
         errors++;
         $display("FAIL basic out2=%h valid=%b cnt=%0d exp a5/0100/1", out2, out_valid, acc_cnt);
      end
      in_valid = 0;
      step(1);
   endtask

   task automatic test_backpressure();
      do_reset();
      in_d = 8'h11; sel = 2'd1; in_valid = 1;
      step(1);
      in_d = 8'h22;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_block in_ready got=%b exp=0", in_ready);
      end
      step(1);
      checks++;
      if (out1 !== 8'h11) begin
         errors++;
         $display("FAIL bp_hold out1 got=%h exp=11", out1);
      end
      out_ready = 4'b0010;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release in_ready got=%b exp=1", in_ready);
      end
      step(1);
      checks++;
      if (out1 !== 8'h22 || out_valid[1] !== 1'b1) begin
         errors++;
         $display("FAIL bp_refill out1=%h v=%b exp 22/1", out1, out_valid[1]);
      end
      in_valid = 0;
      step(1);
   endtask

   task automatic test_streaming();
      do_reset();
      out_ready = 4'b1111; in_valid = 1;
      for (int i = 0; i < 8; i++) begin
         sel = 2'(i);
         in_d = 8'($urandom);
         step(1);
      end
      checks++;
      if (acc_cnt !== 16'd8) begin
         errors++;
         $display("FAIL stream_cnt got=%0d exp=8", acc_cnt);
      end
      in_valid = 0;
      step(1);
   endtask

   task automatic test_enable();
      do_reset();
      in_d = 8'h3C; sel = 2'd3; in_valid = 1;
      step(1);
      en = 0;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         step(1);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL en_block sel=%0d in_ready got=%b exp=0", s, in_ready);
         end
      end
      out_ready = 4'b1000;
      step(1);
      checks++;
      if (out3 !== 8'h00 || out_valid[3] !== 1'b0) begin
         errors++;
         $display("FAIL en_drain out3=%h v=%b exp 00/0", out3, out_valid[3]);
      end
      in_valid = 0;
      en = 1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         in_d = 8'(8'h40 + s);
         step(1);
      end
      rst = 1;
      step(1);
      checks++;
      if (out_valid !== 4'b0000 || acc_cnt !== 16'd0 || out0 !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset valid=%b cnt=%0d exp 0000/0", out_valid, acc_cnt);
      end
      rst = 0; in_valid = 0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 49) == 0);
         en        = ($urandom_range(0, 5) != 0);
         in_valid  = $urandom_range(0, 1);
         in_d      = 8'($urandom);
         sel       = 2'($urandom);
         out_ready = 4'($urandom);
         step(1);
      end
      rst = 0;
   endtask

   task automatic test_wrap();
      do_reset();
      out_ready = 4'b1111; in_valid = 1;
      for (int i = 0; i < 65535; i++) begin
         sel = 2'(i);
         in_d = 8'(i);
         step(0);
      end
      checks++;
      if (acc_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_pre got=%h exp=ffff", acc_cnt);
      end
      step(1);
      checks++;
      if (acc_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL wrap got=%h exp=0000", acc_cnt);
      end
      in_valid = 0;
   endtask

   initial begin
      for (int n = 0; n < 4; n++) begin mv[n] = 0; md[n] = 0; end
      mcnt = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_backpressure();
      test_streaming();
      test_enable();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
